pzcorebus_write_beat_gate: RTL and testbench
============================================

Name: pzcorebus_write_beat_gate

Overview:
- Sits directly downstream of the request command/write-data FIFO pair, at the request master side, in front of the bus fabric.
- Tracks write bursts (up to OUTSTANDING of them) whose command has been accepted downstream.
- Holds back each write-data beat until its command has been handed off.
- Regenerates the per-beat last flag from the command length, so downstream never sees data ahead of its command.

Parameters:
COMMAND_WIDTH, 64, width of packed command payload (opaque here)
DATA_WIDTH, 64, width of packed write-data payload (opaque here)
LENGTH_WIDTH, 8, width of burst length field; field value L means L+1 beats
OUTSTANDING, 4, depth of write-burst tracker FIFO; must be >= 2
COUNT_WIDTH, $clog2(OUTSTANDING+1), width of o_pending (derived)

Ports:
i_clk  input  1  clock
i_rst  input  1  reset, asynchronous, active-high
i_clear  input  1  synchronous clear of tracker, counter and error
i_mcmd_valid  input  1  upstream command valid
o_scmd_accept  output  1  upstream command accept
i_mcmd  input  COMMAND_WIDTH  upstream packed command
i_mcmd_write  input  1  command carries write data
i_mcmd_length  input  LENGTH_WIDTH  beats-1 of the write burst
i_mdata_valid  input  1  upstream write-data valid
o_sdata_accept  output  1  upstream write-data accept
i_mdata  input  DATA_WIDTH  upstream write data
i_mdata_last  input  1  upstream last flag (checked only with macro)
o_mcmd_valid  output  1  downstream command valid
i_scmd_accept  input  1  downstream command accept
o_mcmd  output  COMMAND_WIDTH  downstream command (= i_mcmd)
o_mdata_valid  output  1  downstream write-data valid
i_sdata_accept  input  1  downstream write-data accept
o_mdata  output  DATA_WIDTH  downstream write data (= i_mdata)
o_mdata_last  output  1  regenerated last flag
o_pending  output  COUNT_WIDTH  write bursts tracked, not yet fully sent
o_error  output  1  sticky last-flag mismatch (macro only, else 0)

Behaviour:
- Reset (i_rst high, async):
  - Tracker empty, beat_cnt=0, state IDLE, o_error=0, o_pending=0.
  - o_mcmd_valid, o_mdata_valid and o_mdata_last are 0 while no input is valid.
- i_clear: same effect as reset, applied on the next clock edge.
- Command path is combinational, zero latency:
  - cmd_block = i_mcmd_write && tracker_full.
  - o_mcmd_valid = i_mcmd_valid && !cmd_block.
  - o_scmd_accept = i_scmd_accept && !cmd_block.
  - Non-write commands are never blocked.
- Write command handshake (o_mcmd_valid && i_scmd_accept && i_mcmd_write) pushes i_mcmd_length into the tracker on the clock edge.
- Full uses the registered count only. A pop in the same cycle does not unblock a push.
- Data is allowed one cycle after its command handshake at the earliest. A data beat offered in the same cycle as the handshake is held.
- State machine:
  - IDLE: tracker empty. o_mdata_valid=0, o_sdata_accept=0. Moves to STREAM when the tracker becomes non-empty.
  - STREAM: o_mdata_valid = i_mdata_valid; o_sdata_accept = i_sdata_accept; o_mdata_last = (beat_cnt == head_length).
  - On a beat handshake in STREAM:
    - If not last: beat_cnt++.
    - If last: pop head, beat_cnt<=0. Stay in STREAM if count after pop > 0, else go to IDLE.
- Simultaneous push and pop: count unchanged. A push into an empty tracker makes the head valid next cycle.
- Tracker uses wrap-around pointers of width $clog2(OUTSTANDING).
- o_pending = tracker count, registered.
- Length 0: single beat, o_mdata_last=1 on the first beat.
- Length 2^LENGTH_WIDTH-1: beat_cnt is LENGTH_WIDTH bits wide and counts up to that value without overflow.

Optional Feature:
- Macro PZCOREBUS_WRITE_BEAT_GATE_LAST_CHECK_EN.
- Defined: on each data handshake, if i_mdata_last != o_mdata_last, o_error sets and stays set until i_rst or i_clear. Data flow is unaffected; the regenerated last is still used.
- Undefined: o_error tied 0, i_mdata_last ignored, no compare logic.

Test Plan:
- Write cmd, length=3, data valid from cycle 0 -> data held until cycle after cmd handshake; 4 beats pass; o_mdata_last=1 only on 4th; o_pending 1->0 after beat 4.
- Four write cmds (length 0,1,0,2) with data stalled -> 5th write cmd blocked (o_scmd_accept=0, o_pending=4). A read cmd in the same period passes.
- Tracker full; pop of last beat same cycle as new write cmd -> new cmd still blocked that cycle, accepted next cycle; o_pending goes 4->3->4.
- i_sdata_accept toggled 0/1 on a length=7 burst -> exactly 8 beats; last on 8th; no beat lost or duplicated.
- Reset mid-burst (after 2 of 4 beats) -> o_pending=0, o_mdata_valid=0; a subsequent length=1 burst completes normally.
- Macro defined, i_mdata_last=1 on beat 2 of a length=3 burst -> o_error=1 and sticky; cleared by i_clear. Macro undefined -> o_error=0.

Source files
------------

// File: rtl/pzcorebus_write_beat_gate.sv
// pzcorebus_write_beat_gate
// Holds write-data beats until their command has been accepted downstream,
// tracking up to OUTSTANDING accepted write bursts and regenerating the
// per-beat last flag from each burst's command length.
// Optional: PZCOREBUS_WRITE_BEAT_GATE_LAST_CHECK_EN enables a sticky error
// flag that reports upstream last flags disagreeing with the regenerated one.
module pzcorebus_write_beat_gate #(
    parameter int COMMAND_WIDTH = 64,
    parameter int DATA_WIDTH    = 64,
    parameter int LENGTH_WIDTH  = 8,
    parameter int OUTSTANDING   = 4,
    parameter int COUNT_WIDTH   = $clog2(OUTSTANDING + 1)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_clear,
    input  logic                     i_mcmd_valid,
    output logic                     o_scmd_accept,
    input  logic [COMMAND_WIDTH-1:0] i_mcmd,
    input  logic                     i_mcmd_write,
    input  logic [LENGTH_WIDTH-1:0]  i_mcmd_length,
    input  logic                     i_mdata_valid,
    output logic                     o_sdata_accept,
    input  logic [DATA_WIDTH-1:0]    i_mdata,
    input  logic                     i_mdata_last,
    output logic                     o_mcmd_valid,
    input  logic                     i_scmd_accept,
    output logic [COMMAND_WIDTH-1:0] o_mcmd,
    output logic                     o_mdata_valid,
    input  logic                     i_sdata_accept,
    output logic [DATA_WIDTH-1:0]    o_mdata,
    output logic                     o_mdata_last,
    output logic [COUNT_WIDTH-1:0]   o_pending,
    output logic                     o_error
);

    localparam int PTR_WIDTH = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    logic [LENGTH_WIDTH-1:0] len_mem [OUTSTANDING];

    logic [PTR_WIDTH-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]    rd_ptr_q, rd_ptr_d;
    logic [COUNT_WIDTH-1:0]  count_q, count_d;
    logic [LENGTH_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [0:0]              state_q, state_d;
    logic                    error_q, error_d;

    logic                    tracker_full;
    logic                    cmd_block;
    logic                    streaming;
    logic [LENGTH_WIDTH-1:0] head_length;
    logic                    beat_last;
    logic                    push;
    logic                    beat_hs;
    logic                    pop;

    // Handshake gating: commands blocked only when a write would overflow the
    // tracker; data passes only while a tracked burst is streaming.
    always_comb begin
        tracker_full   = (count_q == COUNT_WIDTH'(OUTSTANDING));
        cmd_block      = i_mcmd_write && tracker_full;
        o_mcmd_valid   = i_mcmd_valid && !cmd_block;
        o_scmd_accept  = i_scmd_accept && !cmd_block;
        o_mcmd         = i_mcmd;
        o_mdata        = i_mdata;
        streaming      = (state_q == ST_STREAM);
        head_length    = len_mem[rd_ptr_q];
        beat_last      = (beat_cnt_q == head_length);
        o_mdata_valid  = streaming && i_mdata_valid;
        o_sdata_accept = streaming && i_sdata_accept;
        o_mdata_last   = streaming && beat_last;
        push           = o_mcmd_valid && i_scmd_accept && i_mcmd_write;
        beat_hs        = o_mdata_valid && i_sdata_accept;
        pop            = beat_hs && beat_last;
        o_pending      = count_q;
        o_error        = error_q;
    end

    // Next-state computation for tracker pointers, count, beat counter, FSM.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        beat_cnt_d = beat_cnt_q;
        state_d    = state_q;
        error_d    = error_q;

        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_WIDTH'(OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_WIDTH'(OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (beat_hs) begin
            beat_cnt_d = pop ? '0 : beat_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE:   if (count_d != '0) state_d = ST_STREAM;
            ST_STREAM: if (pop && (count_d == '0)) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

`ifdef PZCOREBUS_WRITE_BEAT_GATE_LAST_CHECK_EN
        if (beat_hs && (i_mdata_last != beat_last)) begin
            error_d = 1'b1;
        end
`endif

        if (i_clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            beat_cnt_d = '0;
            state_d    = ST_IDLE;
            error_d    = 1'b0;
        end
    end

`ifndef PZCOREBUS_WRITE_BEAT_GATE_LAST_CHECK_EN
    logic unused_mdata_last;
    assign unused_mdata_last = i_mdata_last;
`endif

    // Control state registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            beat_cnt_q <= '0;
            state_q    <= ST_IDLE;
            error_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            beat_cnt_q <= beat_cnt_d;
            state_q    <= state_d;
            error_q    <= error_d;
        end
    end

    // Burst-length storage; contents are only read while the entry is valid.
    always_ff @(posedge i_clk) begin
        if (push) begin
            len_mem[wr_ptr_q] <= i_mcmd_length;
        end
    end

endmodule

// File: tb/tb_pzcorebus_write_beat_gate.sv
// Self-checking bench for pzcorebus_write_beat_gate: directed scenarios plus
// randomized traffic compared against a queue-based model of accepted bursts.
module tb_pzcorebus_write_beat_gate;

    localparam int CW = 64;
    localparam int DW = 64;
    localparam int LW = 8;
    localparam int OS = 4;
    localparam int NW = $clog2(OS + 1);

    logic          clk = 1'b0;
    logic          rst, clear;
    logic          mcmd_valid, mcmd_write, scmd_accept;
    logic [LW-1:0] mcmd_length;
    logic [CW-1:0] mcmd;
    logic          mdata_valid, mdata_last, sdata_accept;
    logic [DW-1:0] mdata;
    logic          o_scmd_accept, o_sdata_accept, o_mcmd_valid, o_mdata_valid;
    logic          o_mdata_last, o_error;
    logic [CW-1:0] o_mcmd;
    logic [DW-1:0] o_mdata;
    logic [NW-1:0] o_pending;

    int checks = 0;
    int errors = 0;

    // Model: queue of accepted write-burst lengths, beat index within head.
    int unsigned mq[$];
    int unsigned mk;
    logic        merr;
    logic        exp_mcmd_valid, exp_scmd_accept, exp_mdata_valid, exp_sdata_accept;
    logic        exp_last, exp_error;
    logic [NW-1:0] exp_pending;

    always #5 clk = ~clk;

    pzcorebus_write_beat_gate #(
        .COMMAND_WIDTH(CW), .DATA_WIDTH(DW), .LENGTH_WIDTH(LW), .OUTSTANDING(OS)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_clear(clear),
        .i_mcmd_valid(mcmd_valid), .o_scmd_accept(o_scmd_accept), .i_mcmd(mcmd),
        .i_mcmd_write(mcmd_write), .i_mcmd_length(mcmd_length),
        .i_mdata_valid(mdata_valid), .o_sdata_accept(o_sdata_accept), .i_mdata(mdata),
        .i_mdata_last(mdata_last),
        .o_mcmd_valid(o_mcmd_valid), .i_scmd_accept(scmd_accept), .o_mcmd(o_mcmd),
        .o_mdata_valid(o_mdata_valid), .i_sdata_accept(sdata_accept), .o_mdata(o_mdata),
        .o_mdata_last(o_mdata_last), .o_pending(o_pending), .o_error(o_error)
    );

    task automatic idle_inputs();
        clear = 0; mcmd_valid = 0; mcmd_write = 0; mcmd_length = '0; mcmd = '0;
        mdata_valid = 0; mdata_last = 0; mdata = '0; scmd_accept = 1; sdata_accept = 1;
    endtask

    // Expected outputs for the current inputs from the model state.
    task automatic settle();
        logic blk, open;
        #1;
        blk = mcmd_write && (mq.size() == OS);
        open = (mq.size() > 0);
        exp_mcmd_valid   = mcmd_valid && !blk;
        exp_scmd_accept  = scmd_accept && !blk;
        exp_mdata_valid  = open && mdata_valid;
        exp_sdata_accept = open && sdata_accept;
        exp_last         = open && (mk == mq[0]);
        exp_pending      = NW'(mq.size());
        exp_error        = merr;
    endtask

    // Advance the model by the handshakes of this cycle, then clock the DUT.
    task automatic tick();
        int unsigned newlen;
        newlen = mcmd_length;
        if (clear) begin
            mq.delete(); mk = 0; merr = 0;
        end else begin
            if (exp_mdata_valid && sdata_accept) begin
`ifdef PZCOREBUS_WRITE_BEAT_GATE_LAST_CHECK_EN
                if (mdata_last != exp_last) merr = 1;
`endif
                if (exp_last) begin
                    void'(mq.pop_front()); mk = 0;
                end else begin
                    mk++;
                end
            end
            if (exp_mcmd_valid && scmd_accept && mcmd_write) mq.push_back(newlen);
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        mq.delete(); mk = 0; merr = 0;
    endtask

    task automatic push_cmd(input int unsigned len);
        mcmd_valid = 1; mcmd_write = 1; mcmd_length = LW'(len); mcmd = {$urandom, $urandom};
        settle(); tick();
        mcmd_valid = 0; mcmd_write = 0;
    endtask

    task automatic test_reset();
        do_reset();
        mdata_valid = 1;
        settle();
        checks++; if (o_pending !== '0) begin errors++; $display("FAIL reset_pending: got %0d want 0", o_pending); end
        checks++; if (o_mdata_valid !== 1'b0) begin errors++; $display("FAIL reset_mdata_valid: got %0b want 0", o_mdata_valid); end
        checks++; if (o_mdata_last !== 1'b0) begin errors++; $display("FAIL reset_mdata_last: got %0b want 0", o_mdata_last); end
        checks++; if (o_mcmd_valid !== 1'b0) begin errors++; $display("FAIL reset_mcmd_valid: got %0b want 0", o_mcmd_valid); end
        checks++; if (o_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %0b want 0", o_error); end
        mdata_valid = 0;
    endtask

    task automatic test_basic();
        do_reset();
        mcmd_valid = 1; mcmd_write = 1; mcmd_length = 3; mdata_valid = 1;
        settle();
        checks++; if (o_mcmd_valid !== 1'b1) begin errors++; $display("FAIL basic_cmd_valid: got %0b want 1", o_mcmd_valid); end
        checks++; if (o_mdata_valid !== 1'b0) begin errors++; $display("FAIL basic_data_held: got %0b want 0", o_mdata_valid); end
        tick();
        mcmd_valid = 0; mcmd_write = 0;
        for (int i = 0; i < 4; i++) begin
            settle();
            checks++; if (o_mdata_valid !== 1'b1) begin errors++; $display("FAIL basic_beat%0d_valid: got %0b want 1", i, o_mdata_valid); end
            checks++; if (o_mdata_last !== (i == 3)) begin errors++; $display("FAIL basic_beat%0d_last: got %0b want %0b", i, o_mdata_last, i == 3); end
            checks++; if (o_pending !== NW'(1)) begin errors++; $display("FAIL basic_beat%0d_pending: got %0d want 1", i, o_pending); end
            tick();
        end
        settle();
        checks++; if (o_pending !== '0) begin errors++; $display("FAIL basic_done_pending: got %0d want 0", o_pending); end
        checks++; if (o_mdata_valid !== 1'b0) begin errors++; $display("FAIL basic_done_valid: got %0b want 0", o_mdata_valid); end
        mdata_valid = 0;
    endtask

    task automatic test_full();
        do_reset();
        push_cmd(0); push_cmd(1); push_cmd(0); push_cmd(2);
        mcmd_valid = 1; mcmd_write = 1; mcmd_length = 0;
        settle();
        checks++; if (o_scmd_accept !== 1'b0) begin errors++; $display("FAIL full_accept: got %0b want 0", o_scmd_accept); end
        checks++; if (o_mcmd_valid !== 1'b0) begin errors++; $display("FAIL full_valid: got %0b want 0", o_mcmd_valid); end
        checks++; if (o_pending !== NW'(4)) begin errors++; $display("FAIL full_pending: got %0d want 4", o_pending); end
        tick();
        mcmd_write = 0;
        settle();
        checks++; if (o_mcmd_valid !== 1'b1 || o_scmd_accept !== 1'b1) begin errors++; $display("FAIL full_read_pass: got %0b%0b want 11", o_mcmd_valid, o_scmd_accept); end
        tick();
        mcmd_valid = 0;
    endtask

    // Runs on the full tracker left by test_full (head length 0).
    task automatic test_pop_push_same_cycle();
        mcmd_valid = 1; mcmd_write = 1; mcmd_length = 5; mdata_valid = 1;
        settle();
        checks++; if (o_mdata_last !== 1'b1) begin errors++; $display("FAIL pp_head_last: got %0b want 1", o_mdata_last); end
        checks++; if (o_scmd_accept !== 1'b0) begin errors++; $display("FAIL pp_blocked: got %0b want 0", o_scmd_accept); end
        tick();
        mdata_valid = 0;
        settle();
        checks++; if (o_pending !== NW'(3)) begin errors++; $display("FAIL pp_pending3: got %0d want 3", o_pending); end
        checks++; if (o_scmd_accept !== 1'b1) begin errors++; $display("FAIL pp_unblocked: got %0b want 1", o_scmd_accept); end
        tick();
        mcmd_valid = 0; mcmd_write = 0;
        settle();
        checks++; if (o_pending !== NW'(4)) begin errors++; $display("FAIL pp_pending4: got %0d want 4", o_pending); end
    endtask

    task automatic burst_count(input int unsigned len, input bit toggle, input string nm);
        int beats = 0;
        int cyc = 0;
        push_cmd(len);
        mdata_valid = 1;
        while (o_pending != 0 && cyc < 2000) begin
            sdata_accept = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
            mdata = {$urandom, $urandom};
            settle();
            if (o_mdata_valid && o_sdata_accept) begin
                beats++;
                checks++; if (o_mdata_last !== (beats == int'(len) + 1)) begin errors++; $display("FAIL %s_last_beat%0d: got %0b want %0b", nm, beats, o_mdata_last, beats == int'(len) + 1); end
            end
            tick();
            cyc++;
        end
        mdata_valid = 0; sdata_accept = 1;
        settle();
        checks++; if (beats != int'(len) + 1) begin errors++; $display("FAIL %s_beats: got %0d want %0d", nm, beats, len + 1); end
        checks++; if (o_mdata_valid !== 1'b0) begin errors++; $display("FAIL %s_idle_valid: got %0b want 0", nm, o_mdata_valid); end
    endtask

    task automatic test_backpressure();
        do_reset();
        burst_count(7, 1'b1, "bp");
    endtask

    task automatic test_max_length();
        do_reset();
        burst_count((1 << LW) - 1, 1'b0, "maxlen");
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        push_cmd(3);
        mdata_valid = 1;
        settle(); tick();
        settle(); tick();
        rst = 1;
        #1;
        checks++; if (o_pending !== '0) begin errors++; $display("FAIL midrst_pending: got %0d want 0", o_pending); end
        checks++; if (o_mdata_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %0b want 0", o_mdata_valid); end
        do_reset();
        burst_count(1, 1'b0, "postrst");
    endtask

    task automatic test_error();
        do_reset();
        push_cmd(3);
        mdata_valid = 1;
        for (int i = 0; i < 4; i++) begin
            mdata_last = (i == 1);
            settle(); tick();
        end
        mdata_valid = 0; mdata_last = 0;
        repeat (2) begin settle(); tick(); end
        settle();
`ifdef PZCOREBUS_WRITE_BEAT_GATE_LAST_CHECK_EN
        checks++; if (o_error !== 1'b1) begin errors++; $display("FAIL err_sticky: got %0b want 1", o_error); end
`else
        checks++; if (o_error !== 1'b0) begin errors++; $display("FAIL err_disabled: got %0b want 0", o_error); end
`endif
        push_cmd(0);
        clear = 1;
        settle(); tick();
        clear = 0;
        settle();
        checks++; if (o_error !== 1'b0) begin errors++; $display("FAIL err_clear: got %0b want 0", o_error); end
        checks++; if (o_pending !== '0) begin errors++; $display("FAIL clear_pending: got %0d want 0", o_pending); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            clear        = ($urandom_range(0, 199) == 0);
            mcmd_valid   = 1'($urandom_range(0, 1));
            mcmd_write   = ($urandom_range(0, 3) != 0);
            mcmd_length  = LW'($urandom_range(0, 4));
            mcmd         = {$urandom, $urandom};
            scmd_accept  = ($urandom_range(0, 3) != 0);
            mdata_valid  = ($urandom_range(0, 2) != 0);
            mdata_last   = ($urandom_range(0, 7) == 0);
            mdata        = {$urandom, $urandom};
            sdata_accept = ($urandom_range(0, 2) != 0);
            settle();
            checks++; if (o_mcmd_valid !== exp_mcmd_valid) begin errors++; $display("FAIL rnd_mcmd_valid c%0d: got %0b want %0b", c, o_mcmd_valid, exp_mcmd_valid); end
            checks++; if (o_scmd_accept !== exp_scmd_accept) begin errors++; $display("FAIL rnd_scmd_accept c%0d: got %0b want %0b", c, o_scmd_accept, exp_scmd_accept); end
            checks++; if (o_mdata_valid !== exp_mdata_valid) begin errors++; $display("FAIL rnd_mdata_valid c%0d: got %0b want %0b", c, o_mdata_valid, exp_mdata_valid); end
            checks++; if (o_sdata_accept !== exp_sdata_accept) begin errors++; $display("FAIL rnd_sdata_accept c%0d: got %0b want %0b", c, o_sdata_accept, exp_sdata_accept); end
            checks++; if (o_mdata_last !== exp_last) begin errors++; $display("FAIL rnd_last c%0d: got %0b want %0b", c, o_mdata_last, exp_last); end
            checks++; if (o_pending !== exp_pending) begin errors++; $display("FAIL rnd_pending c%0d: got %0d want %0d", c, o_pending, exp_pending); end
            checks++; if (o_error !== exp_error) begin errors++; $display("FAIL rnd_error c%0d: got %0b want %0b", c, o_error, exp_error); end
            checks++; if (o_mcmd !== mcmd || o_mdata !== mdata) begin errors++; $display("FAIL rnd_payload c%0d: got %h/%h want %h/%h", c, o_mcmd, o_mdata, mcmd, mdata); end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1;
        mq.delete(); mk = 0; merr = 0;
        idle_inputs();
        test_reset();
        test_basic();
        test_full();
        test_pop_push_same_cycle();
        test_backpressure();
        test_max_length();
        test_reset_mid_burst();
        test_error();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
